// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, default latencies and FSM state type for
// the multiply/divide unit.
// Build option: MULDIV_MADD_EN enables the madd/maddu/msub/msubu ops (6-9).
package muldiv_pkg;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // An op is launchable only if this build implements it.
    function automatic logic op_valid(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: op_valid = 1'b1;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: op_valid = 1'b1;
`endif
            default: op_valid = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        op_is_div = (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_calc.sv
// muldiv_calc: combinational datapath producing the 64-bit {hi,lo} result of
// one multiply/divide op, plus a divide-by-zero flag.
// Build option: MULDIV_MADD_EN adds the accumulate ops ({hi,lo} +/- product).
module muldiv_calc (
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        div0
);
    import muldiv_pkg::*;

    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic [31:0] w_ub;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_sq_mag;
    logic [31:0] w_sr_mag;
    logic [31:0] w_sq;
    logic [31:0] w_sr;

    // Sign/zero extend to 64 bits so the low 64 bits of the product are exact.
    assign w_sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign w_uprod = {32'd0, a} * {32'd0, b};

    // Divisor forced to 1 on b=0 so the dividers never see zero; the result
    // is discarded by the caller in that case.
    assign div0    = (b == 32'd0);
    assign w_ub    = div0 ? 32'd1 : b;
    assign w_abs_a = a[31] ? (~a + 32'd1) : a;
    assign w_abs_b = div0 ? 32'd1 : (b[31] ? (~b + 32'd1) : b);

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. 0x80000000 / -1 wraps to 0x80000000.
    assign w_sq_mag = w_abs_a / w_abs_b;
    assign w_sr_mag = w_abs_a % w_abs_b;
    assign w_sq     = (a[31] ^ b[31]) ? (~w_sq_mag + 32'd1) : w_sq_mag;
    assign w_sr     = a[31] ? (~w_sr_mag + 32'd1) : w_sr_mag;

    // Select the result for the requested op; unknown ops leave {hi,lo} as is.
    always_comb begin
        result = {hi, lo};
        case (op)
            OP_MULT:  result = w_sprod;
            OP_MULTU: result = w_uprod;
            OP_DIV:   result = {w_sr, w_sq};
            OP_DIVU:  result = {a % w_ub, a / w_ub};
`ifdef MULDIV_MADD_EN
            OP_MADD:  result = {hi, lo} + w_sprod;
            OP_MADDU: result = {hi, lo} + w_uprod;
            OP_MSUB:  result = {hi, lo} - w_sprod;
            OP_MSUBU: result = {hi, lo} - w_uprod;
`endif
            default:  result = {hi, lo};
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit owning HI/LO. The result is
// computed in the start cycle, held pending, and committed when the latency
// counter expires; busy is high for exactly the op latency.
// Handshake: start is a one-cycle pulse accepted only while busy=0 and the op
// is valid; busy is registered and rises on the edge that accepts start.
// Build option: MULDIV_MADD_EN enables ops 6-9 (accumulate into {hi,lo}).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mt_we,
    input  logic        mt_hi,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

    state_e           r_state;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      r_pend;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic [63:0]      w_result;
    logic             w_div0;

    muldiv_calc u_calc (
        .op     (op),
        .a      (a),
        .b      (b),
        .hi     (r_hi),
        .lo     (r_lo),
        .result (w_result),
        .div0   (w_div0)
    );

    // FSM: launch ops from IDLE, count down in RUN, commit pending on expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && op_valid(op)) begin
                        // Divide by zero commits the current {hi,lo}, i.e. no change.
                        r_pend  <= (op_is_div(op) && w_div0) ? {r_hi, r_lo} : w_result;
                        r_cnt   <= op_is_div(op) ? CNT_DIV : CNT_MULT;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else if (mt_we && !start) begin
                        if (mt_hi) begin
                            r_hi <= a;
                        end else begin
                            r_lo <= a;
                        end
                    end
                end
                RUN: begin
                    if (r_cnt == CNT_ONE) begin
                        r_hi    <= r_pend[63:32];
                        r_lo    <= r_pend[31:0];
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
